xadc_drp_sequencer: RTL and testbench

// - Sits directly upstream of the per-channel LED PWM stage.
// - On each XADC end-of-conversion, reads the next enabled aux channel over DRP.
// - Conditions the 12-bit result and holds the latest value per channel.
// - Publishes each value as a one-cycle sample strobe and as a packed bus.
// - Replaces ad-hoc address muxing and clocking of captures off drdy edges with a single clk-domain FSM.

---
 rtl/xadc_seq_pkg.sv | 28 ++
 rtl/xadc_rr_pick.sv | 28 ++
 rtl/xadc_drp_sequencer.sv | 151 +++++++++++++++
 tb/tb_xadc_drp_sequencer.sv | 435 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xadc_seq_pkg.sv
// Shared types and constants for the XADC DRP sequencer: FSM states,
// widths and the fixed aux-channel DRP address map.
package xadc_seq_pkg;

    localparam int SAMPLE_W = 12;
    localparam int DRP_AW   = 7;
    localparam int CH_W     = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } seq_state_t;

    // Board wiring: ch0 VAUX14, ch1 VAUX7, ch2 VAUX15, ch3 VAUX6
    function automatic logic [DRP_AW-1:0] chan_addr(input logic [CH_W-1:0] ch);
        logic [DRP_AW-1:0] addr;
        case (ch)
            2'd0:    addr = 7'h1E;
            2'd1:    addr = 7'h17;
            2'd2:    addr = 7'h1F;
            2'd3:    addr = 7'h16;
            default: addr = 7'h1E;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/xadc_rr_pick.sv
// Combinational round-robin picker: first enabled channel after i_last_ch,
// wrapping around to i_last_ch itself when it is the only one enabled.
import xadc_seq_pkg::*;

module xadc_rr_pick #(
    parameter int NUM_CH = 4,
    parameter int CW     = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_ch_en,
    input  logic [CW-1:0]     i_last_ch,
    output logic [CW-1:0]     o_cur,
    output logic              o_any
);

    logic [CW-1:0] w_idx;

    // Scan farthest offset first so the nearest enabled channel wins last
    always_comb begin
        o_any = |i_ch_en;
        o_cur = i_last_ch;
        w_idx = i_last_ch;
        for (int k = NUM_CH; k >= 1; k--) begin
            w_idx = CW'((int'(i_last_ch) + k) % NUM_CH);
            o_cur = i_ch_en[w_idx] ? w_idx : o_cur;
        end
    end

endmodule

// File: rtl/xadc_drp_sequencer.sv
// Reads enabled XADC aux channels over DRP on each eoc and publishes them.
// Optional macro XADC_SEQ_AVG_EN: 4-sample moving average per channel.
import xadc_seq_pkg::*;

module xadc_drp_sequencer #(
    parameter int NUM_CH      = 4,
    parameter int TIMEOUT_CYC = 64,
    parameter int NOISE_MASK  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic                         eoc,
    output logic [DRP_AW-1:0]            drp_daddr,
    output logic                         drp_den,
    input  logic                         drp_drdy,
    input  logic [15:0]                  drp_do,
    output logic                         sample_valid,
    output logic [$clog2(NUM_CH)-1:0]    sample_ch,
    output logic [SAMPLE_W-1:0]          sample_data,
    output logic [NUM_CH*SAMPLE_W-1:0]   ch_data,
    output logic                         timeout_err
);

    localparam int CW = $clog2(NUM_CH);
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    seq_state_t          r_state;
    logic [CW-1:0]       r_cur;
    logic [CW-1:0]       r_last_ch;
    logic [TW-1:0]       r_timer;
    logic [CW-1:0]       w_pick_cur;
    logic                w_pick_any;
    logic [SAMPLE_W-1:0] w_cond;
    logic [SAMPLE_W-1:0] w_result;
    logic                w_capture;

    xadc_rr_pick #(.NUM_CH(NUM_CH), .CW(CW)) u_pick (
        .i_ch_en   (ch_en),
        .i_last_ch (r_last_ch),
        .o_cur     (w_pick_cur),
        .o_any     (w_pick_any)
    );

    // Result sits in drp_do[15:4]; the low nibble is the ground-noise floor
    always_comb begin
        w_cond    = (NOISE_MASK != 0) ? {drp_do[15:8], 4'h0} : drp_do[15:4];
        w_capture = (r_state == WAIT) && drp_drdy && ch_en[r_cur];
    end

`ifdef XADC_SEQ_AVG_EN
    // Three stored samples plus the incoming one form the 4-sample window
    logic [SAMPLE_W-1:0] r_hist [NUM_CH][3];
    logic [SAMPLE_W+1:0] w_sum;

    // Window sum and truncating divide by four
    always_comb begin
        w_sum    = {2'b00, w_cond} + {2'b00, r_hist[r_cur][0]}
                 + {2'b00, r_hist[r_cur][1]} + {2'b00, r_hist[r_cur][2]};
        w_result = w_sum[SAMPLE_W+1:2];
    end

    // Per-channel history shift, cleared while the channel is disabled
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                for (int j = 0; j < 3; j++) begin
                    r_hist[i][j] <= '0;
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!ch_en[i]) begin
                    for (int j = 0; j < 3; j++) begin
                        r_hist[i][j] <= '0;
                    end
                end else if (w_capture && (r_cur == CW'(i))) begin
                    r_hist[i][0] <= w_cond;
                    r_hist[i][1] <= r_hist[i][0];
                    r_hist[i][2] <= r_hist[i][1];
                end
            end
        end
    end
`else
    // Single conditioned sample passes straight through
    always_comb begin
        w_result = w_cond;
    end
`endif

    // Sequencer FSM with registered DRP and sample outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_cur        <= '0;
            r_last_ch    <= CW'(NUM_CH - 1);
            r_timer      <= '0;
            drp_daddr    <= '0;
            drp_den      <= 1'b0;
            sample_valid <= 1'b0;
            sample_ch    <= '0;
            sample_data  <= '0;
            ch_data      <= '0;
            timeout_err  <= 1'b0;
        end else begin
            drp_den      <= 1'b0;
            sample_valid <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!ch_en[i]) begin
                    ch_data[i*SAMPLE_W +: SAMPLE_W] <= '0;
                end
            end
            case (r_state)
                IDLE: begin
                    if (eoc && w_pick_any) begin
                        r_cur   <= w_pick_cur;
                        r_state <= REQ;
                    end
                end
                REQ: begin
                    drp_den   <= 1'b1;
                    drp_daddr <= chan_addr(r_cur);
                    r_timer   <= '0;
                    r_state   <= WAIT;
                end
                WAIT: begin
                    if (drp_drdy) begin
                        r_last_ch <= r_cur;
                        r_state   <= IDLE;
                        // A channel disabled mid-read has its result dropped
                        if (w_capture) begin
                            sample_valid <= 1'b1;
                            sample_ch    <= r_cur;
                            sample_data  <= w_result;
                            ch_data[r_cur*SAMPLE_W +: SAMPLE_W] <= w_result;
                        end
                    end else if (r_timer == TW'(TIMEOUT_CYC - 1)) begin
                        timeout_err <= 1'b1;
                        r_last_ch   <= r_cur;
                        r_state     <= IDLE;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xadc_drp_sequencer.sv
// Scoreboard bench for xadc_drp_sequencer with a behavioural DRP responder.
// Build with XADC_SEQ_AVG_EN defined to also exercise the averaging path.
module tb_xadc_drp_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  ch_en = 4'h0;
    logic        eoc = 1'b0;
    logic [6:0]  drp_daddr;
    logic        drp_den;
    logic        drp_drdy = 1'b0;
    logic [15:0] drp_do = 16'h0000;
    logic        sample_valid;
    logic [1:0]  sample_ch;
    logic [11:0] sample_data;
    logic [47:0] ch_data;
    logic        timeout_err;

    typedef struct {
        logic [1:0]  ch;
        logic [11:0] data;
    } samp_t;

    int          errors = 0;
    int          checks = 0;
    logic [6:0]  addr_q[$];
    samp_t       samp_q[$];
    int          m_last = 3;
    logic [11:0] m_field[4];
    logic [11:0] m_hist[4][3];
    bit          reply_en = 1'b1;
    int          resp_delay = 3;
    int          resp_cnt = 0;
    logic [15:0] resp_data = 16'h0000;
    int          den_cnt = 0;

    xadc_drp_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .ch_en        (ch_en),
        .eoc          (eoc),
        .drp_daddr    (drp_daddr),
        .drp_den      (drp_den),
        .drp_drdy     (drp_drdy),
        .drp_do       (drp_do),
        .sample_valid (sample_valid),
        .sample_ch    (sample_ch),
        .sample_data  (sample_data),
        .ch_data      (ch_data),
        .timeout_err  (timeout_err)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [6:0] exp_addr(input int ch);
        case (ch)
            0:       return 7'h1E;
            1:       return 7'h17;
            2:       return 7'h1F;
            3:       return 7'h16;
            default: return 7'h00;
        endcase
    endfunction

    function automatic int next_ch();
        for (int k = 1; k <= 4; k++) begin
            if (ch_en[(m_last + k) % 4]) return (m_last + k) % 4;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_last = 3;
        for (int i = 0; i < 4; i++) begin
            m_field[i] = 12'h000;
            for (int j = 0; j < 3; j++) m_hist[i][j] = 12'h000;
        end
    endtask

    task automatic set_en(input logic [3:0] en);
        ch_en = en;
        for (int i = 0; i < 4; i++) begin
            if (!en[i]) begin
                m_field[i] = 12'h000;
                for (int j = 0; j < 3; j++) m_hist[i][j] = 12'h000;
            end
        end
    endtask

    // One clock: DRP responder just after the edge, scoreboard on the falling edge
    task automatic tick();
        samp_t      s;
        logic [6:0] ea;
        @(posedge clk);
        #1;
        drp_drdy = 1'b0;
        if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                drp_drdy = 1'b1;
                drp_do   = resp_data;
            end
        end
        if (drp_den === 1'b1 && reply_en) resp_cnt = resp_delay;
        @(negedge clk);
        if (drp_den === 1'b1) begin
            den_cnt++;
            checks++;
            if (addr_q.size() == 0) begin
                errors++;
                $display("FAIL den_unexpected: drp_den=1 daddr=%h, expected no request", drp_daddr);
            end else begin
                ea = addr_q.pop_front();
                if (drp_daddr !== ea) begin
                    errors++;
                    $display("FAIL daddr: got %h expected %h", drp_daddr, ea);
                end
            end
        end
        if (sample_valid === 1'b1) begin
            checks++;
            if (samp_q.size() == 0) begin
                errors++;
                $display("FAIL strobe_unexpected: sample_ch=%0d data=%h, expected no strobe", sample_ch, sample_data);
            end else begin
                s = samp_q.pop_front();
                if (sample_ch !== s.ch) begin
                    errors++;
                    $display("FAIL sample_ch: got %0d expected %0d", sample_ch, s.ch);
                end
                checks++;
                if (sample_data !== s.data) begin
                    errors++;
                    $display("FAIL sample_data: got %h expected %h", sample_data, s.data);
                end
                checks++;
                if (ch_data[int'(s.ch)*12 +: 12] !== s.data) begin
                    errors++;
                    $display("FAIL ch_data_on_strobe ch%0d: got %h expected %h",
                             s.ch, ch_data[int'(s.ch)*12 +: 12], s.data);
                end
            end
        end
    endtask

    // Predict the request (and optionally the sample), then pulse eoc
    task automatic issue_eoc(input bit expect_sample);
        int          c;
        logic [11:0] cond;
        logic [11:0] val;
        logic [13:0] sum;
        c = next_ch();
        if (c >= 0) begin
            addr_q.push_back(exp_addr(c));
            if (expect_sample) begin
                cond = resp_data[15:4] & 12'hFF0;
`ifdef XADC_SEQ_AVG_EN
                sum = 14'(cond) + 14'(m_hist[c][0]) + 14'(m_hist[c][1]) + 14'(m_hist[c][2]);
                val = sum[13:2];
                m_hist[c][2] = m_hist[c][1];
                m_hist[c][1] = m_hist[c][0];
                m_hist[c][0] = cond;
`else
                sum = 14'(cond);
                val = sum[11:0];
`endif
                m_field[c] = val;
                samp_q.push_back('{ch: 2'(c), data: val});
            end
            m_last = c;
        end
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((addr_q.size() != 0 || samp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (addr_q.size() != 0 || samp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d requests and %0d samples outstanding after %0d cycles, expected 0",
                     addr_q.size(), samp_q.size(), n);
            addr_q.delete();
            samp_q.delete();
        end
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if (drp_daddr !== 7'h00) begin
            errors++;
            $display("FAIL reset_daddr: got %h expected 00", drp_daddr);
        end
        checks++;
        if ({drp_den, sample_valid, timeout_err} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: den/valid/timeout got %b expected 000", {drp_den, sample_valid, timeout_err});
        end
        checks++;
        if ({sample_ch, sample_data} !== 14'h0000) begin
            errors++;
            $display("FAIL reset_sample: ch=%0d data=%h expected 0/000", sample_ch, sample_data);
        end
        checks++;
        if (ch_data !== 48'h0) begin
            errors++;
            $display("FAIL reset_ch_data: got %h expected 0", ch_data);
        end
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic test_all_channels();
        int d0 = den_cnt;
        reply_en = 1'b1;
        resp_delay = 3;
        resp_data = 16'hABC0;
        set_en(4'b1111);
        for (int n = 0; n < 4; n++) begin
            issue_eoc(1'b1);
            drain(20);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ch_data[i*12 +: 12] !== m_field[i]) begin
                errors++;
                $display("FAIL all_field ch%0d: got %h expected %h", i, ch_data[i*12 +: 12], m_field[i]);
            end
        end
        checks++;
        if (den_cnt - d0 != 4) begin
            errors++;
            $display("FAIL all_den_count: got %0d expected 4", den_cnt - d0);
        end
    endtask

    task automatic test_two_channels();
        set_en(4'b1001);
        resp_data = 16'h5A7F;
        for (int n = 0; n < 4; n++) begin
            issue_eoc(1'b1);
            drain(20);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (ch_data[i*12 +: 12] !== m_field[i]) begin
                errors++;
                $display("FAIL two_field ch%0d: got %h expected %h", i, ch_data[i*12 +: 12], m_field[i]);
            end
        end
        checks++;
        if (ch_data[35:12] !== 24'h0) begin
            errors++;
            $display("FAIL two_disabled_fields: got %h expected 000000", ch_data[35:12]);
        end
    endtask

    task automatic test_single_and_none();
        int d0;
        set_en(4'b0100);
        resp_data = 16'h1234;
        issue_eoc(1'b1);
        drain(20);
        issue_eoc(1'b1);
        drain(20);
        set_en(4'b0000);
        d0 = den_cnt;
        issue_eoc(1'b0);
        repeat (10) tick();
        checks++;
        if (den_cnt != d0) begin
            errors++;
            $display("FAIL none_den: got %0d requests expected 0", den_cnt - d0);
        end
        checks++;
        if (ch_data !== 48'h0) begin
            errors++;
            $display("FAIL none_ch_data: got %h expected 0", ch_data);
        end
    endtask

    task automatic test_timeout();
        int d0;
        int first_n = 0;
        set_en(4'b1111);
        reply_en = 1'b0;
        d0 = den_cnt;
        issue_eoc(1'b0);
        for (int n = 1; n <= 100; n++) begin
            tick();
            if (first_n == 0 && timeout_err === 1'b1) first_n = n;
        end
        checks++;
        if (first_n != 65) begin
            errors++;
            $display("FAIL timeout_cycle: timeout_err rose at cycle %0d expected 65", first_n);
        end
        checks++;
        if (den_cnt - d0 != 1) begin
            errors++;
            $display("FAIL timeout_den: got %0d requests expected 1", den_cnt - d0);
        end
        reply_en = 1'b1;
        resp_data = 16'h0FF0;
        issue_eoc(1'b1);
        drain(20);
        checks++;
        if (timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL timeout_sticky: got %b expected 1", timeout_err);
        end
    endtask

    task automatic test_eoc_during_wait();
        int d0 = den_cnt;
        resp_delay = 10;
        resp_data = 16'h7770;
        issue_eoc(1'b1);
        repeat (3) tick();
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        tick();
        eoc = 1'b1;
        tick();
        eoc = 1'b0;
        drain(30);
        checks++;
        if (den_cnt - d0 != 1) begin
            errors++;
            $display("FAIL eoc_drop_den: got %0d requests expected 1", den_cnt - d0);
        end
    endtask

    task automatic test_disable_inflight();
        int c;
        logic [3:0] en;
        resp_delay = 5;
        resp_data = 16'hFED0;
        c = next_ch();
        issue_eoc(1'b0);
        repeat (2) tick();
        en = 4'b1111;
        en[c] = 1'b0;
        set_en(en);
        repeat (10) tick();
        checks++;
        if (ch_data[c*12 +: 12] !== 12'h000) begin
            errors++;
            $display("FAIL inflight_field ch%0d: got %h expected 000", c, ch_data[c*12 +: 12]);
        end
        checks++;
        if (addr_q.size() != 0) begin
            errors++;
            $display("FAIL inflight_den: %0d requests missing expected 0", addr_q.size());
            addr_q.delete();
        end
        set_en(4'b1111);
    endtask

    task automatic test_reset_midread();
        resp_delay = 4;
        issue_eoc(1'b0);
        tick();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        model_reset();
        repeat (4) tick();
        checks++;
        if (timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL rst_timeout_clear: got %b expected 0", timeout_err);
        end
        checks++;
        if (ch_data !== 48'h0) begin
            errors++;
            $display("FAIL rst_ch_data: got %h expected 0", ch_data);
        end
        resp_delay = 3;
        resp_data = 16'h4560;
        issue_eoc(1'b1);
        drain(20);
    endtask

`ifdef XADC_SEQ_AVG_EN
    task automatic test_average();
        logic [11:0] exp_avg[4];
        exp_avg = '{12'd100, 12'd300, 12'd500, 12'd700};
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        model_reset();
        set_en(4'b0001);
        resp_delay = 3;
        for (int n = 0; n < 4; n++) begin
            resp_data = (n == 0) ? 16'h1900 : 16'h3200;
            issue_eoc(1'b1);
            drain(20);
            checks++;
            if (ch_data[11:0] !== exp_avg[n]) begin
                errors++;
                $display("FAIL avg_step%0d: got %0d expected %0d", n, ch_data[11:0], exp_avg[n]);
            end
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_all_channels();
        test_two_channels();
        test_single_and_none();
        test_timeout();
        test_eoc_during_wait();
        test_disable_inflight();
        test_reset_midread();
`ifdef XADC_SEQ_AVG_EN
        test_average();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
